vec_issue_seq: RTL and testbench

Registered decode-and-issue sequencer for the vector/scalar ISA. It accepts 16-bit instructions through a valid/ready handshake and latches the decoded fields. It then steps each instruction through its element beats: VLEN beats for vector ops, one beat for scalar ops. It sits between instruction fetch and the vector/scalar execute datapaths, replacing the purely combinational decoder plus external cycle counter.

---
 rtl/vec_issue_seq_pkg.sv | 46 ++++
 rtl/vec_issue_seq_if.sv | 10 +
 rtl/vec_issue_seq_decode.sv | 63 ++++++
 rtl/vec_issue_seq.sv | 157 +++++++++++++++
 tb/tb_vec_issue_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_issue_seq_pkg.sv
// Shared ISA definitions for the vector/scalar issue sequencer:
// opcode constants, FSM state encoding, decoded-instruction record
// and the per-opcode beat count helper.
package vec_isa_pkg;

  localparam logic [3:0] OP_VADD = 4'd0;
  localparam logic [3:0] OP_VDOT = 4'd1;
  localparam logic [3:0] OP_SMUL = 4'd2;
  localparam logic [3:0] OP_SST  = 4'd3;
  localparam logic [3:0] OP_VLD  = 4'd4;
  localparam logic [3:0] OP_VST  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLH  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] dst;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [5:0] off;
    logic [7:0] imm;
    logic       vec_op;     // instruction spans VLEN beats
    logic       v_en;       // vector write on every beat
    logic       s_en;       // scalar write on every beat
    logic       s_en_last;  // scalar write on the final beat only
  } dec_instr_t;

  // Number of element beats an opcode occupies; 0 means drop on accept.
  function automatic int unsigned beats_for(input logic [3:0] op,
                                            input int unsigned vlen);
    case (op)
      OP_VADD, OP_VDOT, OP_SMUL, OP_VLD, OP_VST: return vlen;
      OP_SST, OP_SLL, OP_SLH, OP_J:              return 1;
      default:                                   return 0;
    endcase
  endfunction

endpackage

// File: rtl/vec_issue_seq_if.sv
// Instruction fetch handshake into the issue sequencer.
// master = fetch side, slave = sequencer side.
interface vec_issue_seq_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/vec_issue_seq_decode.sv
// Combinational field decoder: splits a 16-bit instruction into the
// decoded-instruction record. Unused fields are forced to zero.
module isa_field_decode
  import vec_isa_pkg::*;
(
  input  logic [15:0] i_instr,
  output dec_instr_t  o_dec,
  output logic        o_legal
);

  // Field extraction by opcode class
  always_comb begin
    o_dec    = '0;
    o_legal  = 1'b1;
    o_dec.op = i_instr[15:12];
    case (i_instr[15:12])
      OP_VADD, OP_SMUL: begin
        o_dec.dst    = i_instr[11:9];
        o_dec.a1     = i_instr[8:6];
        o_dec.a2     = i_instr[5:3];
        o_dec.vec_op = 1'b1;
        o_dec.v_en   = 1'b1;
      end
      OP_VDOT: begin
        o_dec.dst       = i_instr[11:9];
        o_dec.a1        = i_instr[8:6];
        o_dec.a2        = i_instr[5:3];
        o_dec.vec_op    = 1'b1;
        o_dec.s_en_last = 1'b1;
      end
      OP_VLD: begin
        o_dec.dst    = i_instr[11:9];
        o_dec.a1     = i_instr[8:6];
        o_dec.off    = i_instr[5:0];
        o_dec.vec_op = 1'b1;
        o_dec.v_en   = 1'b1;
      end
      OP_VST: begin
        o_dec.a1     = i_instr[8:6];
        o_dec.a2     = i_instr[11:9];
        o_dec.off    = i_instr[5:0];
        o_dec.vec_op = 1'b1;
      end
      OP_SST: begin
        o_dec.a1  = i_instr[8:6];
        o_dec.a2  = i_instr[11:9];
        o_dec.off = i_instr[5:0];
      end
      OP_SLL, OP_SLH: begin
        o_dec.dst  = i_instr[11:9];
        o_dec.a1   = i_instr[11:9];
        o_dec.imm  = i_instr[7:0];
        o_dec.s_en = 1'b1;
      end
      OP_J: begin
        o_dec.imm = i_instr[7:0];
      end
      OP_NOP: ;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/vec_issue_seq.sv
// Registered decode-and-issue sequencer. Accepts instructions over the
// fetch handshake, latches the decoded fields and steps through the
// element beats (VLEN for vector ops, one for scalar ops), supporting
// back-to-back issue without a bubble and downstream stall.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds `illegal` port
// and a sticky HALT state on undefined opcodes).
module vec_issue_seq
  import vec_isa_pkg::*;
#(
  parameter int unsigned VLEN  = 16,
  parameter int unsigned IDX_W = $clog2(VLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  vec_issue_seq_if.slave    fetch,
  input  logic              stall,
  output logic [3:0]        op,
  output logic [2:0]        dst_addr,
  output logic [2:0]        addr1,
  output logic [2:0]        addr2,
  output logic [5:0]        offset,
  output logic [7:0]        immediate,
  output logic              beat_valid,
  output logic [IDX_W-1:0]  beat_idx,
  output logic              last_beat,
  output logic              v_en,
  output logic              s_en,
  output logic              busy
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  state_e           r_state, w_state_nxt;
  dec_instr_t       r_dec, w_dec_nxt, w_dec_in;
  logic [IDX_W-1:0] r_beat_idx, w_beat_idx_nxt;
  logic [IDX_W-1:0] w_last_idx;
  logic             w_legal;
  logic             w_issue;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_load;
  state_e           w_handoff_state;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic             r_illegal, w_illegal_nxt;
  logic             w_trap;
`endif

  isa_field_decode u_decode (
    .i_instr (fetch.instr),
    .o_dec   (w_dec_in),
    .o_legal (w_legal)
  );

  // Beat position and handshake decoded from registered state
  assign w_issue    = (r_state == ST_ISSUE);
  assign w_last_idx = r_dec.vec_op ? IDX_W'(VLEN - 1) : '0;
  assign w_last     = w_issue && (r_beat_idx == w_last_idx);
  assign w_ready    = (r_state == ST_IDLE) || (w_last && !stall);
  assign w_accept   = fetch.instr_valid && w_ready;
  assign w_load     = w_accept && w_legal &&
                      (beats_for(w_dec_in.op, VLEN) != 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_trap     = w_accept && !w_legal;
`endif

  // Destination state at a hand-off point (IDLE or unstalled last beat)
  always_comb begin
    w_handoff_state = ST_IDLE;
    if (w_load) begin
      w_handoff_state = ST_ISSUE;
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    else if (w_trap) begin
      w_handoff_state = ST_HALT;
    end
`endif
  end

  // Next-state, beat counter and field-latch logic
  always_comb begin
    w_state_nxt    = r_state;
    w_dec_nxt      = r_dec;
    w_beat_idx_nxt = r_beat_idx;
`ifdef DECODE_ILLEGAL_TRAP_EN
    w_illegal_nxt  = r_illegal;
`endif
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = w_handoff_state;
      end
      ST_ISSUE: begin
        if (!stall) begin
          if (!w_last) begin
            w_beat_idx_nxt = r_beat_idx + IDX_W'(1);
          end else begin
            w_state_nxt = w_handoff_state;
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // w_load is only ever true at a hand-off point, so a new instruction
    // overwrites the fields and restarts at beat 0 with no bubble.
    if (w_load) begin
      w_dec_nxt      = w_dec_in;
      w_beat_idx_nxt = '0;
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (w_trap) begin
      w_illegal_nxt = 1'b1;
    end
`endif
  end

  // State and latched-field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dec      <= '0;
      r_beat_idx <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_dec      <= w_dec_nxt;
      r_beat_idx <= w_beat_idx_nxt;
`ifdef DECODE_ILLEGAL_TRAP_EN
      r_illegal  <= w_illegal_nxt;
`endif
    end
  end

  assign fetch.instr_ready = w_ready;
  assign op         = r_dec.op;
  assign dst_addr   = r_dec.dst;
  assign addr1      = r_dec.a1;
  assign addr2      = r_dec.a2;
  assign offset     = r_dec.off;
  assign immediate  = r_dec.imm;
  assign busy       = w_issue;
  assign beat_valid = w_issue;
  assign beat_idx   = r_beat_idx;
  assign last_beat  = w_last;
  assign v_en       = w_issue && r_dec.v_en;
  assign s_en       = w_issue && (r_dec.s_en || (r_dec.s_en_last && w_last));
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal    = r_illegal;
`endif

endmodule

// File: tb/tb_vec_issue_seq.sv
// Scoreboard bench for vec_issue_seq: accepted instructions are expanded
// into expected beats from the ISA table; a monitor compares each cycle.
module tb_vec_issue_seq;
  localparam int unsigned VLEN  = 16;
  localparam int unsigned IDX_W = $clog2(VLEN);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic [3:0]       op;
  logic [2:0]       dst_addr, addr1, addr2;
  logic [5:0]       offset;
  logic [7:0]       immediate;
  logic             beat_valid, last_beat, v_en, s_en, busy;
  logic [IDX_W-1:0] beat_idx;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  vec_issue_seq_if fetch ();

  vec_issue_seq #(.VLEN(VLEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(fetch), .stall(stall),
    .op(op), .dst_addr(dst_addr), .addr1(addr1), .addr2(addr2),
    .offset(offset), .immediate(immediate), .beat_valid(beat_valid),
    .beat_idx(beat_idx), .last_beat(last_beat), .v_en(v_en), .s_en(s_en),
    .busy(busy)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    bit          last, v, s;
    logic [3:0]  op;
    logic [2:0]  dst, a1, a2;
    logic [5:0]  off;
    logic [7:0]  imm;
  } beat_t;

  beat_t q[$];
  bit    halted = 0;
  bit    rand_stall = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expand one accepted instruction into its expected beats
  task automatic model_accept(input logic [15:0] w);
    beat_t       b;
    int unsigned n;
    logic [3:0]  o;
    o = w[15:12];
    b.op = o; b.dst = 0; b.a1 = 0; b.a2 = 0; b.off = 0; b.imm = 0;
    b.v = 0; b.s = 0; b.idx = 0; b.last = 0;
    n = 0;
    case (o)
      4'd0, 4'd1, 4'd2: begin b.dst = w[11:9]; b.a1 = w[8:6]; b.a2 = w[5:3]; n = VLEN; end
      4'd4:             begin b.dst = w[11:9]; b.a1 = w[8:6]; b.off = w[5:0]; n = VLEN; end
      4'd5:             begin b.a1 = w[8:6]; b.a2 = w[11:9]; b.off = w[5:0]; n = VLEN; end
      4'd3:             begin b.a1 = w[8:6]; b.a2 = w[11:9]; b.off = w[5:0]; n = 1; end
      4'd6, 4'd7:       begin b.dst = w[11:9]; b.a1 = w[11:9]; b.imm = w[7:0]; n = 1; end
      4'd8:             begin b.imm = w[7:0]; n = 1; end
      4'd15:            n = 0;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        halted = 1;
`endif
        n = 0;
      end
    endcase
    for (int unsigned i = 0; i < n; i++) begin
      b.idx  = i;
      b.last = (i == n - 1);
      b.v    = (o == 4'd0) || (o == 4'd2) || (o == 4'd4);
      b.s    = (o == 4'd6) || (o == 4'd7) || ((o == 4'd1) && (i == n - 1));
      q.push_back(b);
    end
  endtask

  // Monitor: sample mid-cycle, compare against queue head, record accepts
  initial begin
    beat_t e;
    bit    exp_busy, exp_ready;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        q.delete();
        halted = 0;
        chk("rst_instr_ready", {31'd0, fetch.instr_ready}, 1);
        chk("rst_beat_flags", {27'd0, beat_valid, busy, last_beat, v_en, s_en}, 0);
        chk("rst_fields", {1'b0, op, dst_addr, addr1, addr2, offset, immediate}, 0);
        chk("rst_beat_idx", 32'(beat_idx), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("rst_illegal", {31'd0, illegal}, 0);
`endif
      end else begin
        exp_busy  = (q.size() > 0);
        exp_ready = !halted && ((q.size() == 0) || ((q.size() == 1) && !stall));
        chk("beat_valid", {31'd0, beat_valid}, {31'd0, exp_busy});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("instr_ready", {31'd0, fetch.instr_ready}, {31'd0, exp_ready});
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("illegal", {31'd0, illegal}, {31'd0, halted});
`endif
        if (exp_busy && beat_valid) begin
          e = q[0];
          chk("beat_idx", 32'(beat_idx), e.idx);
          chk("last_beat", {31'd0, last_beat}, {31'd0, e.last});
          chk("v_en", {31'd0, v_en}, {31'd0, e.v});
          chk("s_en", {31'd0, s_en}, {31'd0, e.s});
          chk("op", 32'(op), 32'(e.op));
          chk("dst_addr", 32'(dst_addr), 32'(e.dst));
          chk("addr1", 32'(addr1), 32'(e.a1));
          chk("addr2", 32'(addr2), 32'(e.a2));
          chk("offset", 32'(offset), 32'(e.off));
          chk("immediate", 32'(immediate), 32'(e.imm));
          if (!stall) void'(q.pop_front());
        end else if (!beat_valid) begin
          chk("idle_enables", {29'd0, last_beat, v_en, s_en}, 0);
        end
        if (fetch.instr_valid && exp_ready) model_accept(fetch.instr);
      end
    end
  end

  // Present an instruction until the sequencer takes it (bounded)
  task automatic send(input logic [15:0] w);
    bit ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      fetch.instr       = w;
      fetch.instr_valid = 1'b1;
      stall = rand_stall ? ($urandom_range(3) == 0) : 1'b0;
      #1;
      ok = fetch.instr_ready;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: instr 0x%04h never accepted, instr_ready 0 required 1", w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      fetch.instr_valid = 1'b0;
      stall = rand_stall ? ($urandom_range(3) == 0) : 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_beats;
    int stall_cnt;
    bit found;
    logic [3:0]  ro;
    logic [15:0] rw;
    rst_n = 1'b0; stall = 1'b0;
    fetch.instr = '0; fetch.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // VADD: 16 beats with v_en, last at 15
    send(16'h0A98);
    idle(20);

    // VDOT followed back-to-back by SLL
    send(16'h1254);
    send(16'h6E42);
    idle(4);

    // VLD with a 3-cycle stall at beat 4
    send(16'h4B85);
    n_beats = 0; stall_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      fetch.instr_valid = 1'b0;
      if (beat_valid && beat_idx == IDX_W'(4) && stall_cnt < 3) begin
        stall = 1'b1; stall_cnt++;
      end else begin
        stall = 1'b0;
      end
      #1;
      if (beat_valid) n_beats++;
      else if (n_beats > 0) break;
    end
    chk("vld_stall_duration", n_beats, VLEN + 3);
    idle(2);

    // NOP then J
    send(16'hF000);
    send(16'h80FF);
    idle(3);

    // Reset during SMUL beat 7
    send(16'h2A98);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      fetch.instr_valid = 1'b0;
      #1;
      found = beat_valid && (op == 4'd2) && (beat_idx == IDX_W'(7));
    end
    chk("smul_reached_beat7", {31'd0, found}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0A98);
    idle(20);

    // Undefined opcode
    send(16'h9123);
`ifdef DECODE_ILLEGAL_TRAP_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      fetch.instr = 16'h0A98;
      fetch.instr_valid = 1'b1;
    end
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`else
    send(16'h80AA);
`endif
    idle(3);

    // Randomized traffic with random stall and gaps
    rand_stall = 1;
    for (int i = 0; i < 250; i++) begin
      ro = 4'($urandom_range(15));
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (ro >= 4'd9 && ro <= 4'd14) ro = 4'hF;
`endif
      rw = {ro, 12'($urandom)};
      send(rw);
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    rand_stall = 0;
    idle(3 * VLEN);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
